elevator_interval_timer: RTL and testbench

- Consumer end of the slow-tick chain: receives one divided-frequency square wave, such as the ~1.3 s output, as `tick_in`.
- Synchronizes `tick_in` into the system clock domain and converts each rising edge to a one-cycle tick pulse.
- Counts a loaded number of ticks, then signals completion.
- Used by the elevator controller to time door-open, floor-travel and idle intervals.

---
 rtl/elevator_pkg.sv | 20 ++
 rtl/elevator_interval_timer_tick_sync_edge.sv | 32 +++
 rtl/elevator_interval_timer.sv | 114 +++++++++++
 tb/tb_elevator_interval_timer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator interval timer and its controllers.
package elevator_pkg;

  // Default width of the interval counter (max interval 15 ticks).
  localparam int unsigned CNT_W_DEFAULT = 4;

  // Timer state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } timer_state_e;

  // Tick counts approximating common wall-clock intervals with a ~1.3 s tick.
  localparam int unsigned TICK_1S = 1;
  localparam int unsigned TICK_2S = 2;
  localparam int unsigned TICK_4S = 3;
  localparam int unsigned TICK_8S = 6;

endpackage

// File: rtl/elevator_interval_timer_tick_sync_edge.sv
// Synchronizer chain plus registered rising-edge detector for an asynchronous
// input; reusable for push-button inputs.
module tick_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic pulse_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   pulse_q;

  // Shift the async input through the sync chain; pulse when the last stage
  // is high and the history flop still holds the previous low level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      hist_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q  <= sync_q[SYNC_STAGES-1];
      pulse_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
    end
  end

  assign pulse_out = pulse_q;

endmodule

// File: rtl/elevator_interval_timer.sv
// Interval timer: counts a loaded number of slow tick_in rising edges and
// pulses done on completion. Optional macro ELEVATOR_TIMER_HOLD_EN adds a
// hold input that freezes counting while the door is obstructed.
module elevator_interval_timer
  import elevator_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             start,
  input  logic [CNT_W-1:0] duration,
  input  logic             abort,
`ifdef ELEVATOR_TIMER_HOLD_EN
  input  logic             hold,
`endif
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining,
  output logic             tick_pulse
);

  timer_state_e     state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick_w;
  logic             count_en;

  tick_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_tick_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (tick_in),
    .pulse_out(tick_w)
  );

  // Decide whether the current tick pulse is allowed to count.
  always_comb begin
`ifdef ELEVATOR_TIMER_HOLD_EN
    count_en = tick_w & ~hold;
`else
    count_en = tick_w;
`endif
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state and counter update; abort outranks a coincident tick.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (duration != '0) begin
            state_d     = RUN;
            remaining_d = duration;
          end else begin
            state_d = FIN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d     = IDLE;
          remaining_d = '0;
        end else if (count_en) begin
          if (remaining_q > CNT_W'(1)) begin
            remaining_d = remaining_q - CNT_W'(1);
          end else begin
            remaining_d = '0;
            state_d     = FIN;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        remaining_d = '0;
      end
    endcase
  end

  // Outputs are derived from the next state so they line up with it.
  always_comb begin
    busy_d = (state_d == RUN);
    done_d = (state_d == FIN);
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign remaining  = remaining_q;
  assign tick_pulse = tick_w;

endmodule

// File: tb/tb_elevator_interval_timer.sv
// Scoreboard bench for elevator_interval_timer: stimulus tasks push expected
// events (tick pulses, remaining changes, done pulses) with their cycle
// numbers, and a negedge monitor pops and compares as the DUT produces them.
module tb_elevator_interval_timer;
  import elevator_pkg::*;

  localparam int unsigned CNT_W       = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int          LAT         = SYNC_STAGES + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             tick_in;
  logic             start;
  logic [CNT_W-1:0] duration;
  logic             abort;
  logic             hold_m = 1'b0;
  logic             busy, done, tick_pulse;
  logic [CNT_W-1:0] remaining;

  elevator_interval_timer #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick_in   (tick_in),
    .start     (start),
    .duration  (duration),
    .abort     (abort),
`ifdef ELEVATOR_TIMER_HOLD_EN
    .hold      (hold_m),
`endif
    .busy      (busy),
    .done      (done),
    .remaining (remaining),
    .tick_pulse(tick_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  exp_t rem_exp[$];
  int   pulse_exp[$];
  int   done_exp[$];

  int total = 0;
  int bad   = 0;

  // Transaction-level reference: ticks left in the current interval.
  int model_rem    = 0;
  bit model_active = 1'b0;

  logic [CNT_W-1:0] rem_prev;
  logic             busy_prev;
  bit               mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare DUT events against the scoreboard queues.
  always @(negedge clk) begin
    if (mon_en) begin
      if (tick_pulse) begin
        if (pulse_exp.size() == 0) chk("unexpected tick_pulse", cyc, -1);
        else chk("tick_pulse cycle", cyc, pulse_exp.pop_front());
      end
      if (remaining != rem_prev) begin
        if (rem_exp.size() == 0) begin
          chk("unexpected remaining change", int'(remaining), int'(rem_prev));
        end else begin
          exp_t e;
          e = rem_exp.pop_front();
          chk("remaining value", int'(remaining), e.val);
          chk("remaining cycle", cyc, e.cyc);
        end
      end
      if (remaining != rem_prev || busy != busy_prev)
        chk("busy vs remaining", int'(busy), int'(remaining != '0));
      if (done) begin
        chk("busy low during done", int'(busy), 0);
        if (done_exp.size() == 0) chk("unexpected done", cyc, -1);
        else chk("done cycle", cyc, done_exp.pop_front());
      end
      while (pulse_exp.size() > 0 && pulse_exp[0] < cyc)
        chk("missing tick_pulse", -1, pulse_exp.pop_front());
      while (rem_exp.size() > 0 && rem_exp[0].cyc < cyc) begin
        exp_t e;
        e = rem_exp.pop_front();
        chk("missing remaining change", -1, e.cyc);
      end
      while (done_exp.size() > 0 && done_exp[0] < cyc)
        chk("missing done", -1, done_exp.pop_front());
      rem_prev  = remaining;
      busy_prev = busy;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input int d);
    duration = CNT_W'(d);
    start    = 1'b1;
    if (!model_active) begin
      if (d > 0) begin
        model_active = 1'b1;
        model_rem    = d;
        rem_exp.push_back('{cyc + 1, d});
      end else begin
        done_exp.push_back(cyc + 1);
      end
    end
    step(1);
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    if (model_active) begin
      model_active = 1'b0;
      model_rem    = 0;
      rem_exp.push_back('{cyc + 1, 0});
    end
    step(1);
    abort = 1'b0;
  endtask

  // One tick_in period; with collide set, abort coincides with its pulse.
  task automatic do_tick(input int hi, input int lo, input bit collide);
    int c;
    c       = cyc;
    tick_in = 1'b1;
    pulse_exp.push_back(c + LAT);
    if (model_active) begin
      if (collide) begin
        model_active = 1'b0;
        model_rem    = 0;
        rem_exp.push_back('{c + LAT + 1, 0});
      end else if (!hold_m) begin
        model_rem--;
        rem_exp.push_back('{c + LAT + 1, model_rem});
        if (model_rem == 0) begin
          model_active = 1'b0;
          done_exp.push_back(c + LAT + 1);
        end
      end
    end
    if (collide) begin
      step(LAT);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      step(1);
    end else begin
      step(hi);
    end
    tick_in = 1'b0;
    step(lo);
  endtask

  initial begin
    reset    = 1'b1;
    tick_in  = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    duration = '0;

    // Reset with tick_in toggling, released with tick_in low.
    for (int i = 0; i < 6; i++) begin
      tick_in = ~tick_in;
      step(1);
    end
    @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset remaining", int'(remaining), 0);
    chk("reset tick_pulse", int'(tick_pulse), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("tick_pulse after reset", int'(tick_pulse), 0);
    end
    rem_prev  = remaining;
    busy_prev = busy;
    mon_en    = 1'b1;
    step(1);

    // Normal run of 3 ticks.
    do_start(3);
    step(2);
    chk("busy while running", int'(busy), 1);
    for (int i = 0; i < 3; i++) do_tick(3, 3, 1'b0);
    step(3);
    chk("busy after run", int'(busy), 0);

    // Zero-length interval.
    do_start(0);
    step(4);

    // Abort colliding with the second tick pulse.
    do_start(2);
    step(2);
    do_tick(3, 3, 1'b0);
    do_tick(3, 3, 1'b1);
    step(4);
    chk("idle after collision", int'(remaining), 0);

    // Start ignored while running.
    do_start(5);
    step(2);
    for (int i = 0; i < 3; i++) do_tick(3, 3, 1'b0);
    do_start(5);
    step(1);
    for (int i = 0; i < 2; i++) do_tick(3, 3, 1'b0);
    step(4);

`ifdef ELEVATOR_TIMER_HOLD_EN
    // Hold freezes counting across three ticks.
    do_start(2);
    step(2);
    hold_m = 1'b1;
    for (int i = 0; i < 3; i++) do_tick(3, 3, 1'b0);
    chk("remaining frozen by hold", int'(remaining), 2);
    hold_m = 1'b0;
    step(1);
    for (int i = 0; i < 2; i++) do_tick(3, 3, 1'b0);
    step(4);
`endif

    // Randomized intervals: normal, abort, collision, ignored restart.
    for (int t = 0; t < 40; t++) begin
      int d, mode, k;
      d    = $urandom_range(0, 15);
      mode = $urandom_range(0, 3);
      k    = (d > 0) ? $urandom_range(0, d - 1) : 0;
      repeat ($urandom_range(0, 1)) do_tick($urandom_range(3, 5), $urandom_range(3, 5), 1'b0);
      do_start(d);
      step($urandom_range(1, 3));
      for (int i = 0; i < d; i++) begin
        if (mode == 1 && i == k) begin
          do_abort();
          break;
        end
        if (mode == 3 && i == k) do_start($urandom_range(0, 15));
        do_tick($urandom_range(3, 5), $urandom_range(3, 5), (mode == 2 && i == k));
        if (mode == 2 && i == k) break;
      end
      step(3);
    end

    step(10);
    chk("pending expectations", pulse_exp.size() + rem_exp.size() + done_exp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
